// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    LAP
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int DOT_OVF = 0;
  localparam int DOT_SEC = 2;
  localparam int DOT_LAP = 3;

endpackage

// File: rtl/stopwatch_if.sv
// Display-side bundle: BCD digits, dot mask and status flags.
interface stopwatch_if;
  logic [15:0] o_data;
  logic [3:0]  o_dots;
  logic        o_running;
  logic        o_overflow;

  modport master (
    output o_data,
    output o_dots,
    output o_running,
    output o_overflow
  );

  modport slave (
    input o_data,
    input o_dots,
    input o_running,
    input o_overflow
  );
endinterface

// File: rtl/btn_debounce.sv
// Button synchronizer + debouncer; one-cycle pulse on accepted press.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          diff;
  logic          flip;

  assign diff = s2 ^ o_level;
  assign flip = diff && (cnt == CMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      o_level <= 1'b0;
      o_press <= 1'b0;
    end else begin
      s1      <= i_raw;
      s2      <= s1;
      o_press <= flip & s2;
      if (!diff) begin
        cnt <= '0;
      end else if (flip) begin
        cnt     <= '0;
        o_level <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch FSM, centisecond prescaler, SS.cc BCD chain and lap hold.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 500000,
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_btn_start,
  input  logic       i_btn_lap,
  input  logic       i_btn_clear,
  stopwatch_if.master disp
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic p_start;
  logic p_lap;
  logic p_clear;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .rst_n(rst_n), .i_raw(i_btn_start),
    .o_level(), .o_press(p_start)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk(clk), .rst_n(rst_n), .i_raw(i_btn_lap),
    .o_level(), .o_press(p_lap)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk(clk), .rst_n(rst_n), .i_raw(i_btn_clear),
    .o_level(), .o_press(p_clear)
  );

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc_q;
  bcd_t [3:0]    cnt_q;
  bcd_t [3:0]    cnt_d;
  bcd_t [3:0]    lap_q;
  logic          ovf_q;
  logic          go_idle;
  logic          snap;
  logic          counting;
  logic          tick;
  logic          carry;
  logic [3:0]    dots;

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (presc_q == PMAX);

  // Priority clear > start > lap falls out of the if/else order per state.
  always_comb begin
    state_d = state_q;
    go_idle = 1'b0;
    snap    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (p_clear)      go_idle = 1'b1;
        else if (p_start) state_d = RUN;
      end
      RUN: begin
        if (p_start) begin
          state_d = PAUSED;
        end else if (p_lap) begin
          state_d = LAP;
          snap    = 1'b1;
        end
      end
      PAUSED: begin
        if (p_clear) begin
          state_d = IDLE;
          go_idle = 1'b1;
        end else if (p_start) begin
          state_d = RUN;
        end
      end
      LAP: begin
        if (p_start)    state_d = PAUSED;
        else if (p_lap) state_d = RUN;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    carry = tick;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt_q[i] == 4'd9) begin
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
  end

  // Snapshot takes the post-tick value so the frozen display never lags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (go_idle) begin
        presc_q <= '0;
        cnt_q   <= '0;
        lap_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (counting) presc_q <= tick ? '0 : presc_q + 1'b1;
        cnt_q <= cnt_d;
        if (carry) ovf_q <= 1'b1;
        if (snap)  lap_q <= cnt_d;
      end
    end
  end

  always_comb begin
    dots          = 4'b0000;
    dots[DOT_SEC] = 1'b1;
    dots[DOT_LAP] = (state_q == LAP);
    dots[DOT_OVF] = ovf_q;
  end

  assign disp.o_data     = (state_q == LAP) ? lap_q : cnt_q;
  assign disp.o_dots     = dots;
  assign disp.o_running  = counting;
  assign disp.o_overflow = ovf_q;

endmodule
